// File: rtl/des_ext.sv
// -----------------------------------------------------------------------------
// des_ext -- DES expansion (E-box) stage.
//
// Expands the 32-bit right half-block R to the 48-bit value that feeds the
// round-key XOR / S-box stage. The mapping is a fixed bit permutation with
// duplication, and the result is registered at the output. A valid strobe
// qualifies both input and output.
//
// Bit numbering: ext_data_in[31] is DES bit 1, and ext_data_out[47] is DES
// E-output bit 1 (MSB-first).
//
// Ports:
//   clk_in              in   1   clock; all logic on its rising edge
//   rst_n_in            in   1   synchronous active-low reset
//   ext_data_in         in  32   R half-block
//   ext_data_in_valid   in   1   ext_data_in valid this cycle
//   ext_data_out        out 48   expanded block (holds when no new valid)
//   ext_data_out_valid  out  1   ext_data_out updated this cycle
//
// Configuration macro:
//   DES_EXT_IN_REG_EN   defined   -> an input register stage is added
//                                    (2-cycle latency, 1 per cycle throughput)
//                       undefined -> 1-cycle latency (default)
// -----------------------------------------------------------------------------
module des_ext (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] ext_data_in,
    input  logic        ext_data_in_valid,
    output logic [47:0] ext_data_out,
    output logic        ext_data_out_valid
);

    // The E table as concatenation. Each 6-bit group is the last bit of the
    // previous nibble, the current nibble, and the first bit of the next
    // nibble. The groups wrap around at both ends: DES bit 32 leads, and
    // DES bit 1 trails.
    function automatic logic [47:0] e_expand(input logic [31:0] r);
        e_expand = {r[0],     r[31:27],
                    r[28:23], r[24:19], r[20:15], r[16:11],
                    r[12:7],  r[8:3],
                    r[4:0],   r[31]};
    endfunction

    logic [31:0] stage_data_s;
    logic        stage_valid_s;
    logic [47:0] out_data_r;
    logic        out_valid_r;

`ifdef DES_EXT_IN_REG_EN
    logic [31:0] in_data_r;
    logic        in_valid_r;

    // Optional input register stage. It resets to zero like the outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            in_data_r  <= 32'h0000_0000;
            in_valid_r <= 1'b0;
        end else begin
            in_data_r  <= ext_data_in;
            in_valid_r <= ext_data_in_valid;
        end
    end

    // Feed the output stage from the input register.
    always_comb begin
        stage_data_s  = in_data_r;
        stage_valid_s = in_valid_r;
    end
`else
    // Feed the output stage directly from the ports.
    always_comb begin
        stage_data_s  = ext_data_in;
        stage_valid_s = ext_data_in_valid;
    end
`endif

    // Output register. Data loads only on valid; valid is a registered copy
    // of the strobe.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            out_data_r  <= 48'h0000_0000_0000;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= stage_valid_s;
            if (stage_valid_s) begin
                out_data_r <= e_expand(stage_data_s);
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

    assign ext_data_out       = out_data_r;
    assign ext_data_out_valid = out_valid_r;

endmodule

// File: tb/tb_des_ext.sv
// -----------------------------------------------------------------------------
// tb_des_ext -- directed self-checking bench for des_ext.
// Expected values are hand-computed E-box expansions. The expected latency
// follows DES_EXT_IN_REG_EN.
// -----------------------------------------------------------------------------
module tb_des_ext;

`ifdef DES_EXT_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk_in;
    logic        rst_n_in;
    logic [31:0] ext_data_in;
    logic        ext_data_in_valid;
    logic [47:0] ext_data_out;
    logic        ext_data_out_valid;

    int chk_cnt;
    int pass_cnt;

    des_ext dut (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .ext_data_in        (ext_data_in),
        .ext_data_in_valid  (ext_data_in_valid),
        .ext_data_out       (ext_data_out),
        .ext_data_out_valid (ext_data_out_valid)
    );

    // Free-running clock.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Count a comparison and report it if it mismatches.
    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        chk_cnt = chk_cnt + 1;
        if (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got 0x%012h expected 0x%012h", tag, obs, exp);
        end
    endtask

    // Apply a single 1-cycle valid, then change the data with valid low.
    // The output must appear after LAT cycles as a 1-cycle pulse and then hold.
    task automatic single(input string tag, input logic [31:0] d, input logic [47:0] e);
        fork
            begin
                ext_data_in       = d;
                ext_data_in_valid = 1'b1;
                @(negedge clk_in);
                ext_data_in       = ~d;
                ext_data_in_valid = 1'b0;
            end
            begin
                repeat (LAT) @(negedge clk_in);
                chk({tag, "_data"},  ext_data_out, e);
                chk({tag, "_valid"}, {47'd0, ext_data_out_valid}, 48'd1);
                @(negedge clk_in);
                chk({tag, "_pulse"}, {47'd0, ext_data_out_valid}, 48'd0);
                chk({tag, "_hold"},  ext_data_out, e);
            end
        join
        @(negedge clk_in);
    endtask

    initial begin
        chk_cnt           = 0;
        pass_cnt          = 0;
        rst_n_in          = 1'b0;
        ext_data_in       = 32'h0000_0000;
        ext_data_in_valid = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);
        chk("rst_data",  ext_data_out, 48'h0000_0000_0000);
        chk("rst_valid", {47'd0, ext_data_out_valid}, 48'd0);

        single("vec1", 32'h9199_21A9, 48'hCA3C_F290_3D53);

        // Back-to-back valids must come out on consecutive cycles.
        fork
            begin
                ext_data_in       = 32'h2C45_2C20;
                ext_data_in_valid = 1'b1;
                @(negedge clk_in);
                ext_data_in       = 32'h001C_F302;
                @(negedge clk_in);
                ext_data_in       = 32'hDEAD_BEEF;
                ext_data_in_valid = 1'b0;
            end
            begin
                repeat (LAT) @(negedge clk_in);
                chk("b2b_a_data",  ext_data_out, 48'h1582_0A95_8100);
                chk("b2b_a_valid", {47'd0, ext_data_out_valid}, 48'd1);
                @(negedge clk_in);
                chk("b2b_b_data",  ext_data_out, 48'h0000_F97A_6804);
                chk("b2b_b_valid", {47'd0, ext_data_out_valid}, 48'd1);
                @(negedge clk_in);
                chk("b2b_end_valid", {47'd0, ext_data_out_valid}, 48'd0);
                chk("b2b_end_hold",  ext_data_out, 48'h0000_F97A_6804);
            end
        join
        @(negedge clk_in);

        single("lsb", 32'h0000_0001, 48'h8000_0000_0002);
        single("msb", 32'h8000_0000, 48'h4000_0000_0001);
        single("ones", 32'hFFFF_FFFF, 48'hFFFF_FFFF_FFFF);

        // Reset in the same cycle as a valid input: the input is discarded
        // and no valid pulse appears.
        ext_data_in       = 32'h9199_21A9;
        ext_data_in_valid = 1'b1;
        rst_n_in          = 1'b0;
        @(negedge clk_in);
        ext_data_in_valid = 1'b0;
        rst_n_in          = 1'b1;
        for (int i = 0; i < LAT + 1; i++) begin
            chk("mid_rst_valid", {47'd0, ext_data_out_valid}, 48'd0);
            chk("mid_rst_data",  ext_data_out, 48'h0000_0000_0000);
            @(negedge clk_in);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
